// File: rtl/fault_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fault_pkg
//  Purpose  : Shared widths, severity codes, event record and severity clamp
//             for the fault alarm controller.
//  Revision : 1.0  initial release
// ============================================================================
package fault_pkg;

    localparam int NUM_CH = 4;
    localparam int SEV_W  = 3;
    localparam int CH_W   = 2;
    localparam int EVT_W  = CH_W + SEV_W;

    localparam logic [SEV_W-1:0] SEV_NONE = 3'd0;
    localparam logic [SEV_W-1:0] SEV_LOW  = 3'd1;
    localparam logic [SEV_W-1:0] SEV_MED  = 3'd2;
    localparam logic [SEV_W-1:0] SEV_HIGH = 3'd3;
    localparam logic [SEV_W-1:0] SEV_CRIT = 3'd4;

    // One queued fault event; packs as {ch, sev} for the host read port.
    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [SEV_W-1:0] sev;
    } fault_evt_t;

    // Detector codes above critical are out of range; treat them as critical.
    function automatic logic [SEV_W-1:0] clamp_sev(input logic [SEV_W-1:0] s);
        return (s > SEV_CRIT) ? SEV_CRIT : s;
    endfunction

endpackage : fault_pkg
`default_nettype wire

// File: rtl/fault_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fault_evt_fifo
//  Purpose  : Show-ahead synchronous FIFO. The head entry is always presented
//             on o_rdata; a push into a full FIFO without a pop is dropped and
//             reported on the o_drop pulse.
//  Revision : 1.0  initial release
// ============================================================================
module fault_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);
    // A pop on empty is ignored; a pop frees a slot for a same-cycle push.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage array; contents are only observed while non-empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;
    assign o_drop  = i_push && w_full && !w_do_pop;

endmodule : fault_evt_fifo
`default_nettype wire

// File: rtl/fault_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fault_alarm_ctrl
//  Purpose  : Converts held detector severity/channel into discrete events,
//             queues them for the host, and latches the worst severity per
//             channel to drive alarm/warn until acknowledged.
//  Revision : 1.0  initial release
// ============================================================================
module fault_alarm_ctrl
    import fault_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ALARM_LVL = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             i_sev,
    input  logic [1:0]             i_ch,
    input  logic                   i_rd_en,
    input  logic [3:0]             i_ack,
    input  logic                   i_clr_ovf,
    output logic [4:0]             o_rd_data,
    output logic                   o_rd_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic [11:0]            o_lvl,
    output logic                   o_alarm,
    output logic                   o_warn
);

    localparam logic [SEV_W-1:0] C_ALARM = SEV_W'(ALARM_LVL);

    logic [SEV_W-1:0]        w_sev_c;
    fault_evt_t              w_key;
    logic [EVT_W-1:0]        r_prev_key;
    logic                    w_evt;
    logic                    w_empty;
    logic                    w_drop;
    logic [SEV_W*NUM_CH-1:0] w_lvl_next;
    logic [SEV_W*NUM_CH-1:0] r_lvl;
    logic                    w_alarm_any;
    logic                    w_warn_any;
    logic                    r_overflow;
    logic                    r_alarm;
    logic                    r_warn;

    assign w_sev_c = clamp_sev(i_sev);
    assign w_key   = '{ch: i_ch, sev: w_sev_c};
    // A held input is reported once; dropping to "none" is not an event.
    assign w_evt   = (w_key != r_prev_key) && (w_sev_c != SEV_NONE);

    fault_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_evt),
        .i_wdata (w_key),
        .i_pop   (i_rd_en),
        .o_rdata (o_rd_data),
        .o_empty (w_empty),
        .o_full  (),
        .o_count (o_count),
        .o_drop  (w_drop)
    );

    assign o_rd_valid = !w_empty;

    // Per-channel latch: events raise to the worst seen; ack clears, but an
    // event arriving with its ack restarts the latch at the new severity.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             w_hit;
        logic [SEV_W-1:0] w_cur;
        assign w_hit = w_evt && (i_ch == CH_W'(c));
        assign w_cur = r_lvl[c*SEV_W +: SEV_W];
        assign w_lvl_next[c*SEV_W +: SEV_W] =
            w_hit    ? ((i_ack[c] || (w_sev_c > w_cur)) ? w_sev_c : w_cur) :
            i_ack[c] ? SEV_NONE : w_cur;
    end

    // Summarise the current latches; registered below so alarm/warn lag lvl.
    always_comb begin
        w_alarm_any = 1'b0;
        w_warn_any  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_lvl[c*SEV_W +: SEV_W] >= C_ALARM) begin
                w_alarm_any = 1'b1;
            end
            if (r_lvl[c*SEV_W +: SEV_W] != SEV_NONE) begin
                w_warn_any = 1'b1;
            end
        end
    end

    // Event history, severity latches, indicators and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_key <= '0;
            r_lvl      <= '0;
            r_alarm    <= 1'b0;
            r_warn     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prev_key <= w_key;
            r_lvl      <= w_lvl_next;
            r_alarm    <= w_alarm_any;
            r_warn     <= w_warn_any;
            // A fresh drop outranks a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_lvl      = r_lvl;
    assign o_alarm    = r_alarm;
    assign o_warn     = r_warn;
    assign o_overflow = r_overflow;

endmodule : fault_alarm_ctrl
`default_nettype wire

// File: tb/tb_fault_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fault_alarm_ctrl
//  Purpose  : Directed vector bench for fault_alarm_ctrl (DEPTH=4,
//             ALARM_LVL=3) plus an asynchronous reset sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fault_alarm_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  sev = '0;
    logic [1:0]  ch = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  ack = '0;
    logic        clr_ovf = 1'b0;
    logic [4:0]  rd_data;
    logic        rd_valid;
    logic [2:0]  count;
    logic        overflow;
    logic [11:0] lvl;
    logic        alarm;
    logic        warn;

    int checks = 0;
    int failures = 0;

    fault_alarm_ctrl #(.DEPTH(4), .ALARM_LVL(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_sev      (sev),
        .i_ch       (ch),
        .i_rd_en    (rd_en),
        .i_ack      (ack),
        .i_clr_ovf  (clr_ovf),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_count    (count),
        .o_overflow (overflow),
        .o_lvl      (lvl),
        .o_alarm    (alarm),
        .o_warn     (warn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sev;
        logic [1:0]  ch;
        logic        rd;
        logic [3:0]  ack;
        logic        clr;
        logic [2:0]  e_count;
        logic        e_valid;
        logic [4:0]  e_data;
        logic        e_ovf;
        logic [11:0] e_lvl;
        logic        e_alarm;
        logic        e_warn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] s, input logic [1:0] c,
                                input logic r, input logic [3:0] a,
                                input logic cl, input logic [2:0] ec,
                                input logic ev, input logic [4:0] ed,
                                input logic eo, input logic [11:0] el,
                                input logic ea, input logic ew);
        vec_t v;
        v.sev = s;   v.ch = c;       v.rd = r;      v.ack = a;   v.clr = cl;
        v.e_count = ec; v.e_valid = ev; v.e_data = ed; v.e_ovf = eo;
        v.e_lvl = el;   v.e_alarm = ea; v.e_warn = ew;
        return v;
    endfunction

    // rd_data is only meaningful while the FIFO holds an entry.
    task automatic check_all(input string nm, input logic [2:0] ec,
                             input logic ev, input logic [4:0] ed,
                             input logic eo, input logic [11:0] el,
                             input logic ea, input logic ew);
        logic ok;
        checks++;
        ok = (count == ec) && (rd_valid == ev) && (!ev || rd_data == ed) &&
             (overflow == eo) && (lvl == el) && (alarm == ea) && (warn == ew);
        if (!ok) begin
            failures++;
            $display("FAIL %s: got count=%0d valid=%0b data=%05b ovf=%0b lvl=%03h alarm=%0b warn=%0b; want count=%0d valid=%0b data=%05b ovf=%0b lvl=%03h alarm=%0b warn=%0b",
                     nm, count, rd_valid, rd_data, overflow, lvl, alarm, warn,
                     ec, ev, ed, eo, el, ea, ew);
        end
    endtask

    initial begin
        //                 sev  ch  rd ack     clr  cnt val data      ovf lvl      al wn
        // idle after reset
        vecs.push_back(mk(3'd0,2'd0,0,4'b0000,0, 3'd0,0,5'b00000,0,12'h000,0,0));
        vecs.push_back(mk(3'd0,2'd0,0,4'b0000,0, 3'd0,0,5'b00000,0,12'h000,0,0));
        // held sev=3 ch=2: single event, alarm/warn one cycle after lvl
        vecs.push_back(mk(3'd3,2'd2,0,4'b0000,0, 3'd1,1,5'b10011,0,12'h0C0,0,0));
        vecs.push_back(mk(3'd3,2'd2,0,4'b0000,0, 3'd1,1,5'b10011,0,12'h0C0,1,1));
        vecs.push_back(mk(3'd3,2'd2,0,4'b0000,0, 3'd1,1,5'b10011,0,12'h0C0,1,1));
        vecs.push_back(mk(3'd3,2'd2,0,4'b0000,0, 3'd1,1,5'b10011,0,12'h0C0,1,1));
        vecs.push_back(mk(3'd3,2'd2,0,4'b0000,0, 3'd1,1,5'b10011,0,12'h0C0,1,1));
        vecs.push_back(mk(3'd3,2'd2,1,4'b0000,0, 3'd0,0,5'b00000,0,12'h0C0,1,1));
        vecs.push_back(mk(3'd3,2'd2,0,4'b0100,0, 3'd0,0,5'b00000,0,12'h000,1,1));
        vecs.push_back(mk(3'd0,2'd0,0,4'b0000,0, 3'd0,0,5'b00000,0,12'h000,0,0));
        // ch0: sev 1, 3, 2 each held two cycles
        vecs.push_back(mk(3'd1,2'd0,0,4'b0000,0, 3'd1,1,5'b00001,0,12'h001,0,0));
        vecs.push_back(mk(3'd1,2'd0,0,4'b0000,0, 3'd1,1,5'b00001,0,12'h001,0,1));
        vecs.push_back(mk(3'd3,2'd0,0,4'b0000,0, 3'd2,1,5'b00001,0,12'h003,0,1));
        vecs.push_back(mk(3'd3,2'd0,0,4'b0000,0, 3'd2,1,5'b00001,0,12'h003,1,1));
        vecs.push_back(mk(3'd2,2'd0,0,4'b0000,0, 3'd3,1,5'b00001,0,12'h003,1,1));
        vecs.push_back(mk(3'd2,2'd0,0,4'b0000,0, 3'd3,1,5'b00001,0,12'h003,1,1));
        // pop three in order, then a pop on empty is ignored
        vecs.push_back(mk(3'd2,2'd0,1,4'b0000,0, 3'd2,1,5'b00011,0,12'h003,1,1));
        vecs.push_back(mk(3'd2,2'd0,1,4'b0000,0, 3'd1,1,5'b00010,0,12'h003,1,1));
        vecs.push_back(mk(3'd2,2'd0,1,4'b0000,0, 3'd0,0,5'b00000,0,12'h003,1,1));
        vecs.push_back(mk(3'd2,2'd0,1,4'b0000,0, 3'd0,0,5'b00000,0,12'h003,1,1));
        // fill to DEPTH, fifth (sev=7 clamped to 4) is dropped
        vecs.push_back(mk(3'd1,2'd3,0,4'b0000,0, 3'd1,1,5'b11001,0,12'h203,1,1));
        vecs.push_back(mk(3'd2,2'd3,0,4'b0000,0, 3'd2,1,5'b11001,0,12'h403,1,1));
        vecs.push_back(mk(3'd3,2'd3,0,4'b0000,0, 3'd3,1,5'b11001,0,12'h603,1,1));
        vecs.push_back(mk(3'd4,2'd3,0,4'b0000,0, 3'd4,1,5'b11001,0,12'h803,1,1));
        vecs.push_back(mk(3'd7,2'd1,0,4'b0000,0, 3'd4,1,5'b11001,1,12'h823,1,1));
        vecs.push_back(mk(3'd7,2'd1,0,4'b0000,0, 3'd4,1,5'b11001,1,12'h823,1,1));
        // push with pop while full, then clear, then clear racing a drop
        vecs.push_back(mk(3'd1,2'd2,1,4'b0000,0, 3'd4,1,5'b11010,1,12'h863,1,1));
        vecs.push_back(mk(3'd1,2'd2,0,4'b0000,1, 3'd4,1,5'b11010,0,12'h863,1,1));
        vecs.push_back(mk(3'd2,2'd2,0,4'b0000,1, 3'd4,1,5'b11010,1,12'h8A3,1,1));
        vecs.push_back(mk(3'd2,2'd2,0,4'b0000,1, 3'd4,1,5'b11010,0,12'h8A3,1,1));
        // ack ch0/ch3, then ack ch1 racing an event on ch1 (event wins)
        vecs.push_back(mk(3'd2,2'd2,0,4'b1001,0, 3'd4,1,5'b11010,0,12'h0A0,1,1));
        vecs.push_back(mk(3'd2,2'd1,1,4'b0010,0, 3'd4,1,5'b11011,0,12'h090,1,1));
        vecs.push_back(mk(3'd2,2'd1,0,4'b0000,0, 3'd4,1,5'b11011,0,12'h090,0,1));
        // drain and confirm order
        vecs.push_back(mk(3'd2,2'd1,1,4'b0000,0, 3'd3,1,5'b11100,0,12'h090,0,1));
        vecs.push_back(mk(3'd2,2'd1,1,4'b0000,0, 3'd2,1,5'b10001,0,12'h090,0,1));
        vecs.push_back(mk(3'd2,2'd1,1,4'b0000,0, 3'd1,1,5'b01010,0,12'h090,0,1));
        vecs.push_back(mk(3'd2,2'd1,1,4'b0000,0, 3'd0,0,5'b00000,0,12'h090,0,1));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset_state", 3'd0, 0, 5'b00000, 0, 12'h000, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            sev = vecs[i].sev;  ch = vecs[i].ch;  rd_en = vecs[i].rd;
            ack = vecs[i].ack;  clr_ovf = vecs[i].clr;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_valid,
                      vecs[i].e_data, vecs[i].e_ovf, vecs[i].e_lvl,
                      vecs[i].e_alarm, vecs[i].e_warn);
        end

        // Async reset mid-cycle with two entries queued and input held
        rd_en = 1'b0; ack = '0; clr_ovf = 1'b0;
        sev = 3'd1; ch = 2'd0;
        @(posedge clk); #1;
        sev = 3'd3; ch = 2'd1;
        @(posedge clk); #1;
        check_all("pre_reset", 3'd2, 1, 5'b00001, 0, 12'h099, 0, 1);
        #3;
        reset = 1'b1;
        #1;
        check_all("async_reset", 3'd0, 0, 5'b00000, 0, 12'h000, 0, 0);
        @(posedge clk); #2;
        check_all("reset_held", 3'd0, 0, 5'b00000, 0, 12'h000, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_all("post_reset_evt", 3'd1, 1, 5'b01011, 0, 12'h018, 0, 0);
        @(posedge clk); #1;
        check_all("post_reset_alarm", 3'd1, 1, 5'b01011, 0, 12'h018, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fault_alarm_ctrl
`default_nettype wire
